servo_pwm_ctrl: RTL and testbench
=================================

Name: servo_pwm_ctrl

Overview:
Downstream consumer of the Bluetooth UART receiver's `sel_modo` / `pos_sel` outputs. It drives one hobby-servo PWM line: 50 Hz frame, 1.0–2.0 ms pulse, five discrete positions. Mode A (`sel_modo`=0) jumps straight to the commanded position. Mode B (`sel_modo`=1) slews toward it by a fixed step per frame. Width changes take effect only at frame boundaries, so no pulse is ever truncated or stretched.

Parameters:
- FRAME_CYC, 1000000, clocks per PWM frame (20 ms at 50 MHz).
- PW_MIN, 50000, pulse width for position 1 (1.0 ms).
- PW_STEP, 12500, width increment per position (0.25 ms); position 5 = 100000.
- SLEW, 2500, mode-B width change per frame (0.05 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- sel_modo  in  1  0 = mode A (jump), 1 = mode B (slew).
- pos_sel  in  5  one-hot position request; bit0 = position 1 … bit4 = position 5.
- pwm_out  out  1  servo control pulse.
- pulse_width  out  17  width currently being generated, in clocks.
- moving  out  1  high while pulse_width ≠ target.
- frame_tick  out  1  one-clock strobe in the first cycle of each frame.

Behaviour:
- Reset (reset=0, async):
  - frame counter fc=0, tgt_pw=cur_pw=PW_MIN, state HOLD.
  - pwm_out=0, moving=0, frame_tick=0, pulse_width=PW_MIN.
  - If asserted mid-pulse, pwm_out drops immediately.
- Frame counter:
  - fc is 20 bits, counts 0..FRAME_CYC-1, then wraps to 0.
  - frame_tick=1 exactly in the cycles where fc==0.
- PWM output:
  - Registered; pwm_out=1 in the cycles where fc < cur_pw, otherwise 0.
  - Each frame is exactly cur_pw high clocks followed by FRAME_CYC-cur_pw low clocks.
  - The high run starts coincident with frame_tick.
- Target decode:
  - Each clock, if pos_sel is exactly one-hot, tgt_pw <= PW_MIN + k·PW_STEP, where k = index of the set bit.
  - Zero or multi-hot pos_sel leaves tgt_pw unchanged.
  - sel_modo is registered each clock (mode_r).
- Boundary update: only in the cycle fc==FRAME_CYC-1. The new cur_pw applies from the next frame.
  - mode_r=0: cur_pw <= tgt_pw.
  - mode_r=1 and |tgt_pw-cur_pw| ≤ SLEW: cur_pw <= tgt_pw.
  - mode_r=1 otherwise: cur_pw <= cur_pw ± SLEW, toward target.
  - Arithmetic is unsigned 17-bit; the compare selects direction before subtracting, so there is no underflow.
- FSM (state transitions only in the boundary cycle):
  - HOLD → SLEW_UP when tgt>cur and mode B.
  - HOLD → SLEW_DN when tgt<cur and mode B.
  - Any state → HOLD when cur_pw reaches tgt after the update, including every mode-A update.
  - SLEW_UP ↔ SLEW_DN if the target crosses cur_pw mid-ramp; the new direction applies on the same boundary.
  - Mode B→A mid-ramp: the next boundary jumps to target, state → HOLD.
- moving is combinational from registers: moving = (cur_pw ≠ tgt_pw). It can rise mid-frame when the target changes.
- A target change mid-frame never alters the frame in progress.
- pulse_width = cur_pw.
- cur_pw is always within [PW_MIN, PW_MIN+4·PW_STEP].

Test Plan:
- Release reset, pos_sel=00001, sel_modo=0 → every frame 1000000 clks, pwm_out high 50000 clks, frame_tick once per frame, moving=0.
- Mode A, pos_sel 00001→10000 at fc=20000 → current frame still 50000 high; next frame 100000 high; moving=0 after that boundary.
- Mode B, pos_sel 00001→10000 → successive widths 52500, 55000, …, 100000 (20 frames); moving=1 until the frame generating 100000, then 0.
- Mode B ramping up at 70000, pos_sel→00001 → next widths 67500, 65000, …, 50000; state SLEW_UP→SLEW_DN.
- pos_sel=00011, then 00000, while at 75000 → width stays 75000, moving=0. Mode B at 60000, switch sel_modo→0 with target 100000 → next frame 100000.
- reset low at fc=30000 during a 75000 pulse → pwm_out=0 immediately. After release: fc restarts at 0, first frame 50000 high, pulse_width=50000.

Source files
------------

// File: rtl/servo_pwm_ctrl.sv
// Single-channel hobby-servo PWM generator: 50 Hz frame, five discrete
// positions, instant jump (mode A) or per-frame slew (mode B).
module servo_pwm_ctrl #(
  parameter int unsigned FRAME_CYC = 1000000,
  parameter int unsigned PW_MIN    = 50000,
  parameter int unsigned PW_STEP   = 12500,
  parameter int unsigned SLEW      = 2500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_modo,
  input  logic [4:0]  pos_sel,
  output logic        pwm_out,
  output logic [16:0] pulse_width,
  output logic        moving,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    SLEW_UP = 2'd1,
    SLEW_DN = 2'd2
  } state_e;

  localparam logic [19:0] FC_LAST = 20'(FRAME_CYC - 1);
  localparam logic [16:0] PMIN    = 17'(PW_MIN);
  localparam logic [16:0] PSTEP   = 17'(PW_STEP);
  localparam logic [16:0] PSLEW   = 17'(SLEW);

  logic [19:0] fc_q, fc_d;
  logic [16:0] tgt_q, tgt_d;
  logic [16:0] cur_q, cur_d;
  logic        mode_q;
  logic        pwm_q;
  logic        tick_q;
  state_e      st_q, st_d;
  logic        boundary;

  assign boundary = (fc_q == FC_LAST);
  assign fc_d     = boundary ? 20'd0 : fc_q + 20'd1;

  always_comb begin
    tgt_d = tgt_q;
    if ($onehot(pos_sel)) begin
      unique case (1'b1)
        pos_sel[0]: tgt_d = PMIN;
        pos_sel[1]: tgt_d = PMIN + PSTEP;
        pos_sel[2]: tgt_d = PMIN + 17'd2 * PSTEP;
        pos_sel[3]: tgt_d = PMIN + 17'd3 * PSTEP;
        pos_sel[4]: tgt_d = PMIN + 17'd4 * PSTEP;
        default:    tgt_d = tgt_q;
      endcase
    end
  end

  // Direction is chosen before subtracting, so the difference never wraps.
  always_comb begin
    cur_d = cur_q;
    st_d  = st_q;
    if (boundary) begin
      if (!mode_q || tgt_q == cur_q) begin
        cur_d = tgt_q;
        st_d  = HOLD;
      end else if (tgt_q > cur_q) begin
        if (tgt_q - cur_q <= PSLEW) begin
          cur_d = tgt_q;
          st_d  = HOLD;
        end else begin
          cur_d = cur_q + PSLEW;
          st_d  = SLEW_UP;
        end
      end else begin
        if (cur_q - tgt_q <= PSLEW) begin
          cur_d = tgt_q;
          st_d  = HOLD;
        end else begin
          cur_d = cur_q - PSLEW;
          st_d  = SLEW_DN;
        end
      end
    end
  end

  // Outputs trail fc by one clock so tick and the high run start together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fc_q   <= 20'd0;
      tgt_q  <= PMIN;
      cur_q  <= PMIN;
      mode_q <= 1'b0;
      pwm_q  <= 1'b0;
      tick_q <= 1'b0;
      st_q   <= HOLD;
    end else begin
      fc_q   <= fc_d;
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      mode_q <= sel_modo;
      pwm_q  <= (fc_q < 20'(cur_q));
      tick_q <= (fc_q == 20'd0);
      st_q   <= st_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_tick  = tick_q;
  assign pulse_width = cur_q;
  assign moving      = (cur_q != tgt_q);

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Bench for servo_pwm_ctrl with a scaled-down frame; frame-level
// reference model of the target/width rules.
module tb_servo_pwm_ctrl;

  localparam int F     = 100;
  localparam int PMIN  = 20;
  localparam int PSTEP = 10;
  localparam int PSLEW = 3;
  localparam int PMAX  = PMIN + 4 * PSTEP;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel_modo;
  logic [4:0]  pos_sel;
  logic        pwm_out;
  logic [16:0] pulse_width;
  logic        moving;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int m_cur;
  int m_tgt;
  logic m_mode;

  servo_pwm_ctrl #(
    .FRAME_CYC(F),
    .PW_MIN   (PMIN),
    .PW_STEP  (PSTEP),
    .SLEW     (PSLEW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel_modo   (sel_modo),
    .pos_sel    (pos_sel),
    .pwm_out    (pwm_out),
    .pulse_width(pulse_width),
    .moving     (moving),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input logic [4:0] p, input int keep);
    if ($countones(p) != 1) return keep;
    for (int k = 0; k < 5; k++)
      if (p[k]) return PMIN + k * PSTEP;
    return keep;
  endfunction

  function automatic int next_width(input int cur, input int tgt,
                                    input logic md);
    int d;
    if (!md) return tgt;
    d = tgt - cur;
    if (d > PSLEW) return cur + PSLEW;
    if (d < -PSLEW) return cur - PSLEW;
    return tgt;
  endfunction

  // Called at the negedge of a frame_tick cycle; leaves at the next one.
  task automatic run_frame(input int chg, input logic [4:0] np,
                           input logic nm);
    int hi = 0;
    int ticks = 0;
    int bad = 0;
    chk("pulse_width", int'(pulse_width), m_cur);
    chk("tick_at_start", int'(frame_tick), 1);
    for (int i = 0; i < F; i++) begin
      if (frame_tick) ticks++;
      if (pwm_out !== (i < m_cur)) bad++;
      if (pwm_out) hi++;
      if (i == chg) begin
        pos_sel  = np;
        sel_modo = nm;
        m_tgt    = width_of(np, m_tgt);
        m_mode   = nm;
      end
      if (i == F - 2)
        chk("moving", int'(moving), int'(m_cur != m_tgt));
      @(negedge clk);
    end
    chk("ticks_per_frame", ticks, 1);
    chk("high_clocks", hi, m_cur);
    chk("pulse_shape_errs", bad, 0);
    m_cur = next_width(m_cur, m_tgt, m_mode);
    if (m_cur < PMIN || m_cur > PMAX) chk("model_range", m_cur, PMIN);
  endtask

  task automatic settle(input logic [4:0] p, input logic md);
    int n = 0;
    run_frame(3, p, md);
    while (m_cur != m_tgt && n < 30) begin
      run_frame(-1, p, md);
      n++;
    end
    chk("settle_bound", int'(m_cur == m_tgt), 1);
  endtask

  task automatic sync();
    int n = 0;
    while (!frame_tick && n < 2 * F) begin
      @(negedge clk);
      n++;
    end
    chk("sync", int'(frame_tick), 1);
  endtask

  initial begin
    reset    = 1'b0;
    sel_modo = 1'b0;
    pos_sel  = 5'b00001;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_pw", int'(pulse_width), PMIN);
    chk("rst_moving", int'(moving), 0);
    reset  = 1'b1;
    m_cur  = PMIN;
    m_tgt  = PMIN;
    m_mode = 1'b0;
    sync();
    run_frame(-1, 5'b00001, 1'b0);
    run_frame(-1, 5'b00001, 1'b0);

    // Mode A jump mid-frame: current frame untouched.
    run_frame(20, 5'b10000, 1'b0);
    chk("jump_width", m_cur, PMAX);
    run_frame(-1, 5'b10000, 1'b0);

    // Mode B full ramp up.
    settle(5'b00001, 1'b0);
    settle(5'b10000, 1'b1);
    run_frame(-1, 5'b10000, 1'b1);

    // Reversal mid-ramp.
    settle(5'b00001, 1'b0);
    run_frame(5, 5'b10000, 1'b1);
    for (int n = 0; n < 30 && m_cur < PMIN + 15; n++)
      run_frame(-1, 5'b10000, 1'b1);
    settle(5'b00001, 1'b1);

    // Illegal requests leave the target alone.
    settle(5'b00100, 1'b0);
    run_frame(10, 5'b00011, 1'b1);
    run_frame(10, 5'b00000, 1'b1);
    chk("illegal_hold", int'(pulse_width), PMIN + 2 * PSTEP);

    // Mode B to A mid-ramp jumps straight to target.
    run_frame(5, 5'b00001, 1'b1);
    run_frame(-1, 5'b00001, 1'b1);
    run_frame(5, 5'b10000, 1'b0);
    chk("b_to_a", int'(pulse_width), PMAX);
    run_frame(-1, 5'b10000, 1'b0);

    // Random requests, modes and change points.
    for (int r = 0; r < 40; r++)
      run_frame(int'($urandom_range(F - 10, 1)),
                5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)));

    // Asynchronous reset mid-pulse.
    settle(5'b00100, 1'b0);
    repeat (10) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm_out), 1);
    reset = 1'b0;
    #1;
    chk("async_pwm", int'(pwm_out), 0);
    chk("async_pw", int'(pulse_width), PMIN);
    chk("async_moving", int'(moving), 0);
    @(negedge clk);
    reset  = 1'b1;
    m_cur  = PMIN;
    m_tgt  = width_of(pos_sel, PMIN);
    m_mode = sel_modo;
    sync();
    run_frame(-1, 5'b00100, 1'b0);
    run_frame(-1, 5'b00100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
